// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
//   Bundles the signals of one requester port of ram_port_arbiter.
//   master modport: requester side (drives req/we/lock/addr/wdata).
//   slave  modport: arbiter side (drives gnt/rvalid/rdata).
//   Signals:
//     req    access request, held until gnt
//     we     1 = write, 0 = read
//     lock   keep ownership after this access while high
//     addr   word address
//     wdata  write data
//     gnt    access accepted this cycle (combinational)
//     rvalid read data valid this cycle (one cycle after a read transfer)
//     rdata  RAM read data, qualify with rvalid
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) ();
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//   Shares one single-port synchronous-read RAM between port 0 (CPU
//   load/store) and port 1 (host readout). Per-cycle req/gnt arbitration,
//   multi-cycle lock for read-modify-write, and per-port read-valid tracking
//   for the RAM's one-cycle read latency.
//
//   Build option: ARB_ROUND_ROBIN_EN
//     defined   - contested IDLE cycles alternate between the ports
//     undefined - port 0 has priority; port 1 is forced through after
//                 MAX_WAIT consecutive denials
//
//   Ports:
//     clk        clock, all state on rising edge
//     rst        synchronous active-high reset
//     m0, m1     requester ports (ram_port_arbiter_if.slave)
//     ram_we     RAM write enable
//     ram_addr   RAM word address
//     ram_wdata  RAM write data
//     ram_rdata  RAM read data, valid one cycle after the address
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   m0,
    ram_port_arbiter_if.slave   m1,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] req;
    logic [1:0] we;
    logic [1:0] lock;
    logic [1:0] gnt;
    logic [1:0] rvalid_q;
    logic       pick1;      // contested IDLE cycle goes to port 1

    assign req  = {m1.req,  m0.req};
    assign we   = {m1.we,   m0.we};
    assign lock = {m1.lock, m0.lock};

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner_q, last_winner_d;

    assign pick1 = (last_winner_q == 1'b0);

    always_comb begin
        last_winner_d = last_winner_q;
        if (gnt[0])
            last_winner_d = 1'b0;
        else if (gnt[1])
            last_winner_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_winner_q <= 1'b1;
        else
            last_winner_q <= last_winner_d;
    end
`else
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign pick1 = (wait_cnt_q == WAIT_W'(MAX_WAIT));

    // Counts consecutive denied port-1 requests; saturates so a long lock
    // held by port 0 cannot wrap it back below the force threshold.
    always_comb begin
        wait_cnt_d = '0;
        if (req[1] && !gnt[1])
            wait_cnt_d = pick1 ? wait_cnt_q : wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt_q <= '0;
        else
            wait_cnt_q <= wait_cnt_d;
    end
`endif

    // Grant and next-state. gnt is forced low during reset so nothing
    // reaches the RAM and no read is tracked while rst is high.
    always_comb begin
        gnt     = 2'b00;
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req == 2'b11)
                    gnt = pick1 ? 2'b10 : 2'b01;
                else
                    gnt = req;
                if (gnt[0] && lock[0])
                    state_d = OWN0;
                else if (gnt[1] && lock[1])
                    state_d = OWN1;
            end
            OWN0: begin
                gnt[0] = req[0];
                if (!lock[0])
                    state_d = IDLE;
            end
            OWN1: begin
                gnt[1] = req[1];
                if (!lock[1])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst)
            gnt = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // RAM drive: winner's request, all zero when nobody is granted.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt[1]) begin
            ram_we    = m1.we;
            ram_addr  = m1.addr;
            ram_wdata = m1.wdata;
        end else if (gnt[0]) begin
            ram_we    = m0.we;
            ram_addr  = m0.addr;
            ram_wdata = m0.wdata;
        end
    end

    // Read-valid per port: a read transfer this cycle means RAM data for
    // that port next cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
        always_ff @(posedge clk) begin
            if (rst)
                rvalid_q[gi] <= 1'b0;
            else
                rvalid_q[gi] <= gnt[gi] & ~we[gi];
        end
    end

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    assign m0.rvalid = rvalid_q[0];
    assign m1.rvalid = rvalid_q[1];
    assign m0.rdata  = ram_rdata;
    assign m1.rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
//   Directed tests for ram_port_arbiter with a behavioural synchronous RAM.
//   Inputs change just after the falling edge; combinational outputs are
//   checked 1 ns later, registered outputs right at the falling edge.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] mem [32];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Single-port RAM, read-first, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic idle_inputs();
        m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.lock = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
        m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.lock = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.addr = 5'd5; m0_if.wdata = 32'h5555_5555;
        m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 5'd6;
        #1;
        vectors++; if (m0_if.gnt !== 1'b0) begin miscompares++; $display("FAIL reset_m0_gnt: got %b expected 0", m0_if.gnt); end
        vectors++; if (m1_if.gnt !== 1'b0) begin miscompares++; $display("FAIL reset_m1_gnt: got %b expected 0", m1_if.gnt); end
        vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
        next_cycle();
        vectors++; if (m1_if.rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m1_rvalid: got %b expected 0", m1_if.rvalid); end
        vectors++; if (m0_if.rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m0_rvalid: got %b expected 0", m0_if.rvalid); end
        vectors++; if (dut.state_q !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", dut.state_q); end
`ifndef ARB_ROUND_ROBIN_EN
        vectors++; if (dut.wait_cnt_q !== 3'd0) begin miscompares++; $display("FAIL reset_wait_cnt: got %0d expected 0", dut.wait_cnt_q); end
`endif
        rst = 1'b0;
        idle_inputs();
        $display("test_reset: done");
    endtask

    task automatic test_idle_bus();
        do_reset();
        m0_if.addr = 5'd9; m0_if.wdata = 32'h0000_0123; m0_if.we = 1'b1;
        m1_if.addr = 5'd4; m1_if.wdata = 32'hFFFF_0000;
        #1;
        vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL idle_ram_we: got %b expected 0", ram_we); end
        vectors++; if (ram_addr !== 5'd0) begin miscompares++; $display("FAIL idle_ram_addr: got %0d expected 0", ram_addr); end
        vectors++; if (ram_wdata !== 32'd0) begin miscompares++; $display("FAIL idle_ram_wdata: got %h expected 0", ram_wdata); end
        idle_inputs();
        $display("test_idle_bus: no request, bus parked at zero");
    endtask

    task automatic test_write_read();
        do_reset();
        m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.addr = 5'd3; m0_if.wdata = 32'hDEAD_BEEF;
        #1;
        vectors++; if (m0_if.gnt !== 1'b1) begin miscompares++; $display("FAIL wr_m0_gnt: got %b expected 1", m0_if.gnt); end
        vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("FAIL wr_ram_we: got %b expected 1", ram_we); end
        vectors++; if (ram_addr !== 5'd3) begin miscompares++; $display("FAIL wr_ram_addr: got %0d expected 3", ram_addr); end
        vectors++; if (ram_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_ram_wdata: got %h expected deadbeef", ram_wdata); end
        $display("test_write_read: m0 write addr 3 data deadbeef");
        next_cycle();
        vectors++; if (m0_if.rvalid !== 1'b0) begin miscompares++; $display("FAIL wr_no_rvalid: got %b expected 0", m0_if.rvalid); end
        m0_if.we = 1'b0; m0_if.wdata = '0;
        #1;
        vectors++; if (m0_if.gnt !== 1'b1) begin miscompares++; $display("FAIL rd_m0_gnt: got %b expected 1", m0_if.gnt); end
        vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL rd_ram_we: got %b expected 0", ram_we); end
        $display("test_write_read: m0 read addr 3");
        next_cycle();
        idle_inputs();
        vectors++; if (m0_if.rvalid !== 1'b1) begin miscompares++; $display("FAIL rd_m0_rvalid: got %b expected 1", m0_if.rvalid); end
        vectors++; if (m0_if.rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_m0_rdata: got %h expected deadbeef", m0_if.rdata); end
        vectors++; if (m1_if.rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_m1_rvalid: got %b expected 0", m1_if.rvalid); end
        next_cycle();
        vectors++; if (m0_if.rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_rvalid_drop: got %b expected 0", m0_if.rvalid); end
    endtask

`ifndef ARB_ROUND_ROBIN_EN
    task automatic test_fixed_priority();
        logic prev0, prev1, exp1;
        do_reset();
        prev0 = 1'b0; prev1 = 1'b0;
        m0_if.req = 1'b1; m0_if.addr = 5'd1;
        m1_if.req = 1'b1; m1_if.addr = 5'd2;
        for (int i = 0; i < 10; i++) begin
            exp1 = ((i % 5) == 4);
            vectors++; if (m0_if.rvalid !== prev0) begin miscompares++; $display("FAIL fixed_m0_rvalid[%0d]: got %b expected %b", i, m0_if.rvalid, prev0); end
            vectors++; if (m1_if.rvalid !== prev1) begin miscompares++; $display("FAIL fixed_m1_rvalid[%0d]: got %b expected %b", i, m1_if.rvalid, prev1); end
            #1;
            vectors++; if (dut.wait_cnt_q !== 3'(i % 5)) begin miscompares++; $display("FAIL fixed_wait_cnt[%0d]: got %0d expected %0d", i, dut.wait_cnt_q, i % 5); end
            vectors++; if (m0_if.gnt !== ~exp1) begin miscompares++; $display("FAIL fixed_m0_gnt[%0d]: got %b expected %b", i, m0_if.gnt, ~exp1); end
            vectors++; if (m1_if.gnt !== exp1) begin miscompares++; $display("FAIL fixed_m1_gnt[%0d]: got %b expected %b", i, m1_if.gnt, exp1); end
            $display("test_fixed_priority: cycle %0d winner m%0d", i, exp1);
            prev0 = ~exp1; prev1 = exp1;
            next_cycle();
        end
        // two more denials, then port 1 drops its request: counter clears
        vectors++; if (dut.wait_cnt_q !== 3'd0) begin miscompares++; $display("FAIL fixed_wait_after_gnt: got %0d expected 0", dut.wait_cnt_q); end
        next_cycle();
        next_cycle();
        vectors++; if (dut.wait_cnt_q !== 3'd2) begin miscompares++; $display("FAIL fixed_wait_two: got %0d expected 2", dut.wait_cnt_q); end
        m1_if.req = 1'b0;
        next_cycle();
        vectors++; if (dut.wait_cnt_q !== 3'd0) begin miscompares++; $display("FAIL fixed_wait_drop: got %0d expected 0", dut.wait_cnt_q); end
        idle_inputs();
        next_cycle();
    endtask
`else
    task automatic test_round_robin();
        logic exp0;
        do_reset();
        m0_if.req = 1'b1; m0_if.addr = 5'd1;
        m1_if.req = 1'b1; m1_if.addr = 5'd2;
        for (int i = 0; i < 8; i++) begin
            exp0 = ((i % 2) == 0);
            #1;
            vectors++; if (m0_if.gnt !== exp0) begin miscompares++; $display("FAIL rr_m0_gnt[%0d]: got %b expected %b", i, m0_if.gnt, exp0); end
            vectors++; if (m1_if.gnt !== ~exp0) begin miscompares++; $display("FAIL rr_m1_gnt[%0d]: got %b expected %b", i, m1_if.gnt, ~exp0); end
            $display("test_round_robin: cycle %0d winner m%0d", i, ~exp0);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask
`endif

    task automatic test_lock();
        do_reset();
        m1_if.req = 1'b1; m1_if.lock = 1'b1; m1_if.addr = 5'd7;
        #1;
        vectors++; if (m1_if.gnt !== 1'b1) begin miscompares++; $display("FAIL lock_acquire_gnt: got %b expected 1", m1_if.gnt); end
        $display("test_lock: m1 locked read addr 7");
        next_cycle();
        m1_if.req = 1'b0;
        m0_if.req = 1'b1; m0_if.addr = 5'd4;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                vectors++; if (m1_if.rvalid !== 1'b1) begin miscompares++; $display("FAIL lock_m1_rvalid: got %b expected 1", m1_if.rvalid); end
            end
            m1_if.req = (k == 1); m1_if.we = 1'b1; m1_if.wdata = 32'h0000_0077;
            #1;
            vectors++; if (m0_if.gnt !== 1'b0) begin miscompares++; $display("FAIL lock_m0_denied[%0d]: got %b expected 0", k, m0_if.gnt); end
            vectors++; if (m1_if.gnt !== (k == 1)) begin miscompares++; $display("FAIL lock_m1_gnt[%0d]: got %b expected %b", k, m1_if.gnt, k == 1); end
            vectors++; if (ram_we !== (k == 1)) begin miscompares++; $display("FAIL lock_ram_we[%0d]: got %b expected %b", k, ram_we, k == 1); end
            next_cycle();
            vectors++; if (m0_if.rvalid !== 1'b0) begin miscompares++; $display("FAIL lock_m0_no_rvalid[%0d]: got %b expected 0", k, m0_if.rvalid); end
        end
        m1_if.req = 1'b0; m1_if.lock = 1'b0;
        #1;
        vectors++; if (m0_if.gnt !== 1'b0) begin miscompares++; $display("FAIL lock_release_cycle: got %b expected 0", m0_if.gnt); end
        next_cycle();
        #1;
        vectors++; if (m0_if.gnt !== 1'b1) begin miscompares++; $display("FAIL lock_m0_after: got %b expected 1", m0_if.gnt); end
        $display("test_lock: lock released, m0 granted");
        next_cycle();
        idle_inputs();
        vectors++; if (m0_if.rvalid !== 1'b1) begin miscompares++; $display("FAIL lock_m0_rvalid: got %b expected 1", m0_if.rvalid); end
        next_cycle();
    endtask

    task automatic test_reset_lock();
        do_reset();
        m0_if.req = 1'b1; m0_if.lock = 1'b1; m0_if.addr = 5'd3;
        #1;
        vectors++; if (m0_if.gnt !== 1'b1) begin miscompares++; $display("FAIL rstlock_acquire: got %b expected 1", m0_if.gnt); end
        next_cycle();
        vectors++; if (dut.state_q !== 2'd1) begin miscompares++; $display("FAIL rstlock_own0: got %0d expected 1", dut.state_q); end
        rst = 1'b1;
        #1;
        vectors++; if (m0_if.gnt !== 1'b0) begin miscompares++; $display("FAIL rstlock_gnt: got %b expected 0", m0_if.gnt); end
        vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL rstlock_ram_we: got %b expected 0", ram_we); end
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        vectors++; if (dut.state_q !== 2'd0) begin miscompares++; $display("FAIL rstlock_state: got %0d expected 0", dut.state_q); end
        vectors++; if (m0_if.rvalid !== 1'b0) begin miscompares++; $display("FAIL rstlock_m0_rvalid: got %b expected 0", m0_if.rvalid); end
        vectors++; if (m1_if.rvalid !== 1'b0) begin miscompares++; $display("FAIL rstlock_m1_rvalid: got %b expected 0", m1_if.rvalid); end
        m1_if.req = 1'b1; m1_if.addr = 5'd2;
        #1;
        vectors++; if (m1_if.gnt !== 1'b1) begin miscompares++; $display("FAIL rstlock_m1_gnt: got %b expected 1", m1_if.gnt); end
        $display("test_reset_lock: reset released m0 lock, m1 granted");
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.addr = 5'd1; m0_if.wdata = 32'h0000_0011;
        #1;
        vectors++; if (m0_if.gnt !== 1'b1) begin miscompares++; $display("FAIL b2b_wr0_gnt: got %b expected 1", m0_if.gnt); end
        next_cycle();
        idle_inputs();
        m1_if.req = 1'b1; m1_if.we = 1'b1; m1_if.addr = 5'd2; m1_if.wdata = 32'h0000_0022;
        #1;
        vectors++; if (m1_if.gnt !== 1'b1) begin miscompares++; $display("FAIL b2b_wr1_gnt: got %b expected 1", m1_if.gnt); end
        vectors++; if (ram_addr !== 5'd2) begin miscompares++; $display("FAIL b2b_wr1_addr: got %0d expected 2", ram_addr); end
        vectors++; if (ram_wdata !== 32'h0000_0022) begin miscompares++; $display("FAIL b2b_wr1_wdata: got %h expected 22", ram_wdata); end
        next_cycle();
        idle_inputs();
        vectors++; if (m1_if.rvalid !== 1'b0) begin miscompares++; $display("FAIL b2b_wr1_rvalid: got %b expected 0", m1_if.rvalid); end
        m0_if.req = 1'b1; m0_if.addr = 5'd1;
        $display("test_back_to_back: m0 read addr 1");
        next_cycle();
        idle_inputs();
        m1_if.req = 1'b1; m1_if.addr = 5'd2;
        #1;
        vectors++; if (m1_if.gnt !== 1'b1) begin miscompares++; $display("FAIL b2b_rd1_gnt: got %b expected 1", m1_if.gnt); end
        vectors++; if (m0_if.rvalid !== 1'b1) begin miscompares++; $display("FAIL b2b_m0_rvalid: got %b expected 1", m0_if.rvalid); end
        vectors++; if (m0_if.rdata !== 32'h0000_0011) begin miscompares++; $display("FAIL b2b_m0_rdata: got %h expected 11", m0_if.rdata); end
        vectors++; if (m1_if.rvalid !== 1'b0) begin miscompares++; $display("FAIL b2b_m1_early: got %b expected 0", m1_if.rvalid); end
        $display("test_back_to_back: m1 read addr 2");
        next_cycle();
        idle_inputs();
        vectors++; if (m1_if.rvalid !== 1'b1) begin miscompares++; $display("FAIL b2b_m1_rvalid: got %b expected 1", m1_if.rvalid); end
        vectors++; if (m1_if.rdata !== 32'h0000_0022) begin miscompares++; $display("FAIL b2b_m1_rdata: got %h expected 22", m1_if.rdata); end
        vectors++; if (m0_if.rvalid !== 1'b0) begin miscompares++; $display("FAIL b2b_m0_late: got %b expected 0", m0_if.rvalid); end
        next_cycle();
        vectors++; if (m1_if.rvalid !== 1'b0) begin miscompares++; $display("FAIL b2b_m1_drop: got %b expected 0", m1_if.rvalid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_bus();
        test_write_read();
`ifndef ARB_ROUND_ROBIN_EN
        test_fixed_priority();
`else
        test_round_robin();
`endif
        test_lock();
        test_reset_lock();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
